// File: rtl/lsu_apb_multibeat_if.sv
// rtl/lsu_apb_multibeat_if.sv - request, beat response and APB signal bundle for lsu_apb_multibeat
// The master modport is the load/store unit; the slave modport is its environment.
interface lsu_apb_multibeat_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16
);
  logic                start_i;
  logic                dir_i;
  logic [1:0]          size_i;
  logic                ext_i;
  logic [ADDR_W-1:0]   addr_i;
  logic [DATA_W-1:0]   wdata_i;
  logic                ready_o;
  logic                valid_o;
  logic                last_o;
  logic                err_o;
  logic [OUT_W-1:0]    ldata_o;
  logic [ADDR_W-1:0]   paddr_o;
  logic                psel_o;
  logic                penable_o;
  logic                pwrite_o;
  logic [DATA_W-1:0]   pwdata_o;
  logic [DATA_W/8-1:0] pstrb_o;
  logic [DATA_W-1:0]   prdata_i;
  logic                pready_i;
  logic                pslverr_i;

  modport master (
    input  start_i, dir_i, size_i, ext_i, addr_i, wdata_i,
    output ready_o, valid_o, last_o, err_o, ldata_o,
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    output start_i, dir_i, size_i, ext_i, addr_i, wdata_i,
    input  ready_o, valid_o, last_o, err_o, ldata_o,
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/lsu_apb_multibeat.sv
// rtl/lsu_apb_multibeat.sv - APB load/store unit with misaligned split, load extension and narrow beat drain
// All outputs decode from registered state, so an asynchronous reset drops the bus immediately.
module lsu_apb_multibeat #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUT_W       = 16,
  parameter int MISALIGN_EN = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input logic                 clk,
  input logic                 rst,
  lsu_apb_multibeat_if.master bus
);
  localparam int BPW    = DATA_W / 8;
  localparam int SW     = 2 * BPW;
  localparam int OFF_W  = $clog2(BPW);
  localparam int NB     = DATA_W / OUT_W;
  localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP1, S_ACCESS1, S_SETUP2, S_ACCESS2, S_DRAIN, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [1:0]          size_q, size_d;
  logic                ext_q, ext_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mis_q, mis_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [DATA_W-1:0]   rdata2_q, rdata2_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [31:0]         wait_q, wait_d;

  logic [OFF_W-1:0]    req_off;
  logic                req_mis;
  logic                req_bad;
  logic [OFF_W-1:0]    off;
  logic [ADDR_W-1:0]   base_addr;
  logic [SW-1:0]       strb_wide;
  logic [2*DATA_W-1:0] wdata_wide;
  logic [2*DATA_W-1:0] rdata_wide;
  logic                sign;
  logic [7:0]          fill;
  logic [DATA_W-1:0]   result;
  logic                timeout_hit;
  logic                drain_done;

  // Decode of the incoming request, used only on the capture cycle.
  always_comb begin
    req_off = bus.addr_i[OFF_W-1:0];
    req_mis = (32'(req_off) + (32'd1 << bus.size_i)) > 32'(BPW);
    req_bad = ((bus.size_i == 2'd3) && (DATA_W < 64)) || (req_mis && (MISALIGN_EN == 0));
  end

  // Lane steering: both bus words are viewed as one double-width window.
  always_comb begin
    off        = addr_q[OFF_W-1:0];
    base_addr  = addr_q & ~ADDR_W'(BPW - 1);
    strb_wide  = ((SW'(1) << (32'd1 << size_q)) - SW'(1)) << off;
    wdata_wide = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
    rdata_wide = {rdata2_q, rdata1_q} >> {off, 3'b000};
    sign       = rdata_wide[(32'd8 << size_q) - 32'd1];
    fill       = {8{ext_q & sign}};
    result     = '0;
    for (int i = 0; i < BPW; i++) begin
      result[8*i +: 8] = (32'(i) < (32'd1 << size_q)) ? rdata_wide[8*i +: 8] : fill;
    end
  end

  always_comb begin
    timeout_hit = (TIMEOUT_CYC > 0) && (wait_q == 32'(TIMEOUT_CYC - 1)) && !bus.pready_i;
    drain_done  = dir_q || (beat_q == BEAT_W'(NB - 1));
  end

  always_comb begin
    bus.psel_o    = 1'b0;
    bus.penable_o = 1'b0;
    bus.pwrite_o  = 1'b0;
    bus.paddr_o   = '0;
    bus.pstrb_o   = '0;
    bus.pwdata_o  = '0;
    if (state_q == S_SETUP1 || state_q == S_ACCESS1) begin
      bus.psel_o    = 1'b1;
      bus.penable_o = (state_q == S_ACCESS1);
      bus.pwrite_o  = dir_q;
      bus.paddr_o   = base_addr;
      bus.pstrb_o   = strb_wide[BPW-1:0];
      bus.pwdata_o  = wdata_wide[DATA_W-1:0];
    end else if (state_q == S_SETUP2 || state_q == S_ACCESS2) begin
      bus.psel_o    = 1'b1;
      bus.penable_o = (state_q == S_ACCESS2);
      bus.pwrite_o  = dir_q;
      bus.paddr_o   = base_addr + ADDR_W'(BPW);
      bus.pstrb_o   = strb_wide[SW-1:BPW];
      bus.pwdata_o  = wdata_wide[2*DATA_W-1:DATA_W];
    end
  end

  always_comb begin
    bus.ready_o = (state_q == S_IDLE);
    bus.err_o   = (state_q == S_ERR);
    bus.valid_o = (state_q == S_DRAIN);
    bus.last_o  = (state_q == S_DRAIN) && drain_done;
    bus.ldata_o = '0;
    if (state_q == S_DRAIN && !dir_q) begin
      bus.ldata_o = result[32'(beat_q) * OUT_W +: OUT_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    size_d   = size_q;
    ext_d    = ext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mis_d    = mis_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          dir_d    = bus.dir_i;
          size_d   = bus.size_i;
          ext_d    = bus.ext_i;
          addr_d   = bus.addr_i;
          wdata_d  = bus.wdata_i;
          mis_d    = req_mis;
          rdata1_d = '0;
          rdata2_d = '0;
          beat_d   = '0;
          state_d  = req_bad ? S_ERR : S_SETUP1;
        end
      end
      S_SETUP1: begin
        wait_d  = '0;
        state_d = S_ACCESS1;
      end
      S_ACCESS1: begin
        if (bus.pready_i) begin
          if (bus.pslverr_i) begin
            state_d = S_ERR;
          end else begin
            rdata1_d = bus.prdata_i;
            state_d  = mis_q ? S_SETUP2 : S_DRAIN;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_SETUP2: begin
        wait_d  = '0;
        state_d = S_ACCESS2;
      end
      S_ACCESS2: begin
        if (bus.pready_i) begin
          if (bus.pslverr_i) begin
            state_d = S_ERR;
          end else begin
            rdata2_d = bus.prdata_i;
            state_d  = S_DRAIN;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      size_q   <= 2'd0;
      ext_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      beat_q   <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      size_q   <= size_d;
      ext_q    <= ext_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mis_q    <= mis_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
    end
  end
endmodule
